// File: rtl/rpsc_startup_sequencer.sv
// RPSC channel start-up sequencer: fan -> CA PS -> ramp -> delay -> RUN, with cooldown and latched FAULT.
// Optional macro RPSC_FIRST_FAULT_EN enables the first-fault cause code on fault_code.
//
// state  | meaning
// IDLE   | all commands off, waiting for start_req
// FAN_UP | fan commanded, waiting for fan_act (timeout -> FAULT 1)
// CA_REQ | CA PS commanded, waiting for ca_ps_act (timeout -> FAULT 2)
// RAMP   | CA ramp, over-current/under-voltage masked
// DELAY  | CA settle delay
// RUN    | channel ready
// COOL   | CA off, fan run-on, then IDLE
// FAULT  | CA off, fan on, wait for fault_clr with interlocks clear

module rpsc_startup_sequencer #(
  parameter int          CNT_W       = 26,
  parameter int unsigned FAN_TMO_CYC = 3906250,
  parameter int unsigned RAMP_CYC    = 3125000,
  parameter int unsigned DELAY_CYC   = 46875000,
  parameter int unsigned COOL_CYC    = 23437500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_req,
  input  logic       stop_req,
  input  logic       fault_clr,
  input  logic       fan_act,
  input  logic       intlk_ok,
  input  logic       g1_ok,
  input  logic       ca_ps_act,
  input  logic       i_ca_high,
  input  logic       u_ca_low,
  output logic       fan_on_cmd,
  output logic       ca_on_cmd,
  output logic       ready,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FAN_UP = 3'd1,
    S_CA_REQ = 3'd2,
    S_RAMP   = 3'd3,
    S_DELAY  = 3'd4,
    S_RUN    = 3'd5,
    S_COOL   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] FAN_LD   = CNT_W'(FAN_TMO_CYC - 1);
  localparam logic [CNT_W-1:0] RAMP_LD  = CNT_W'(RAMP_CYC - 1);
  localparam logic [CNT_W-1:0] DELAY_LD = CNT_W'(DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] COOL_LD  = CNT_W'(COOL_CYC - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, load_val;
  logic             expired, in_seq;
  logic [2:0]       trip_code;

  assign expired = (cnt == '0);
  assign in_seq  = state inside {S_FAN_UP, S_CA_REQ, S_RAMP, S_DELAY, S_RUN};
  assign state_o = state;

  // Trip priority encoder; 0 means no trip.
  always_comb begin
    trip_code = 3'd0;
    if (in_seq) begin
      if (!intlk_ok)
        trip_code = 3'd3;
      else if (!g1_ok)
        trip_code = 3'd4;
      else if (state != S_FAN_UP && !fan_act)
        trip_code = 3'd5;
      else if ((state inside {S_DELAY, S_RUN}) && (i_ca_high || u_ca_low))
        trip_code = 3'd6;
      else if ((state inside {S_RAMP, S_DELAY, S_RUN}) && !ca_ps_act)
        trip_code = 3'd7;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_req && !stop_req && intlk_ok && g1_ok) state_nxt = S_FAN_UP;
      S_FAN_UP: if (fan_act) state_nxt = S_CA_REQ;
                else if (expired) state_nxt = S_FAULT;
      S_CA_REQ: if (ca_ps_act) state_nxt = S_RAMP;
                else if (expired) state_nxt = S_FAULT;
      S_RAMP:   if (expired) state_nxt = S_DELAY;
      S_DELAY:  if (expired) state_nxt = S_RUN;
      S_RUN:    state_nxt = S_RUN;
      S_COOL:   if (expired) state_nxt = S_IDLE;
      S_FAULT:  if (fault_clr && intlk_ok && g1_ok) state_nxt = S_COOL;
      default:  state_nxt = S_IDLE;
    endcase
    // Orderly stop beats normal progress and timeouts; any trip beats everything.
    if (in_seq && stop_req)
      state_nxt = S_COOL;
    if (trip_code != 3'd0)
      state_nxt = S_FAULT;
  end

  always_comb begin
    load_val = '0;
    case (state_nxt)
      S_FAN_UP, S_CA_REQ: load_val = FAN_LD;
      S_RAMP:             load_val = RAMP_LD;
      S_DELAY:            load_val = DELAY_LD;
      S_COOL:             load_val = COOL_LD;
      default:            load_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      fan_on_cmd <= 1'b0;
      ca_on_cmd  <= 1'b0;
      ready      <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        cnt <= load_val;
      else if (!expired)
        cnt <= cnt - 1'b1;
      fan_on_cmd <= (state_nxt != S_IDLE);
      ca_on_cmd  <= state_nxt inside {S_CA_REQ, S_RAMP, S_DELAY, S_RUN};
      ready      <= (state_nxt == S_RUN);
      fault      <= (state_nxt == S_FAULT);
    end
  end

`ifdef RPSC_FIRST_FAULT_EN
  logic [2:0] fault_code_q;

  // A fault entry without a trip can only be a FAN_UP or CA_REQ timeout.
  always_ff @(posedge clk) begin
    if (reset)
      fault_code_q <= 3'd0;
    else if (state != S_FAULT && state_nxt == S_FAULT)
      fault_code_q <= (trip_code != 3'd0) ? trip_code :
                      (state == S_FAN_UP) ? 3'd1 : 3'd2;
    else if (state == S_FAULT && state_nxt != S_FAULT)
      fault_code_q <= 3'd0;
  end

  assign fault_code = fault_code_q;
`else
  assign fault_code = 3'd0;
`endif

endmodule
